// File: rtl/matrix_disp_formatter_if.sv
// rtl/matrix_disp_formatter_if.sv - request, storage read and tx byte stream signals of the display formatter
interface matrix_disp_formatter_if;
    logic       disp_req;
    logic [3:0] disp_id;
    logic [2:0] disp_m;
    logic [2:0] disp_n;
    logic       start_disp;
    logic [3:0] matrix_id_out;
    logic       read_en;
    logic       meta_valid;
    logic [7:0] elem_data;
    logic       elem_valid;
    logic       store_err;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  disp_req, disp_id, disp_m, disp_n, meta_valid, elem_data, elem_valid,
               store_err, tx_ready,
        output start_disp, matrix_id_out, read_en, tx_data, tx_valid, busy, done, err
    );

    modport slave (
        output disp_req, disp_id, disp_m, disp_n, meta_valid, elem_data, elem_valid,
               store_err, tx_ready,
        input  start_disp, matrix_id_out, read_en, tx_data, tx_valid, busy, done, err
    );
endinterface

// File: rtl/matrix_disp_formatter.sv
// rtl/matrix_disp_formatter.sv - fetches a stored matrix and streams it as decimal ASCII text
// Optional "M<id>:<m>x<n>" header line enabled by defining MATRIX_DISP_HEADER_EN.
module matrix_disp_formatter #(
    parameter int         META_TIMEOUT = 15,
    parameter logic [7:0] SEP_CHAR     = 8'h20
) (
    input logic                     clk,
    input logic                     rst,
    matrix_disp_formatter_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, REQ, WAIT_META, FETCH, WAIT_DATA, CONV, EMIT, EOL_CR, EOL_LF, FIN, FAIL
    } state_t;

    state_t     state;
    logic [3:0] id_q;
    logic [2:0] m_q, n_q, row, col;
    logic [7:0] meta_cnt;
    logic [7:0] elem_q;
    logic       store_err_q;
    logic [7:0] char_buf [0:8];
    logic [3:0] char_len, char_idx;
    logic       start_disp_q, read_en_q, tx_valid_q, busy_q, done_q, err_q;
    logic [7:0] tx_data_q;

    logic [7:0] mag, rem, hund, tens, ones;
    logic [7:0] conv_buf [0:8];
    logic [3:0] conv_len;

    // Digit split by constant compares keeps the conversion to a single cycle.
    always_comb begin
        mag  = elem_q[7] ? (~elem_q + 8'd1) : elem_q;
        hund = (mag >= 8'd100) ? 8'd1 : 8'd0;
        rem  = (mag >= 8'd100) ? (mag - 8'd100) : mag;
        tens = 8'd0;
        for (int k = 1; k < 10; k++) begin
            if (rem >= 8'(k * 10)) tens = 8'(k);
        end
        ones     = rem - 8'(tens * 8'd10);
        conv_buf = '{default: 8'h00};
        conv_len = 4'd0;
        if (elem_q[7]) begin
            conv_buf[conv_len] = 8'h2D;
            conv_len = conv_len + 4'd1;
        end
        if (hund != 8'd0) begin
            conv_buf[conv_len] = 8'h30 + hund;
            conv_len = conv_len + 4'd1;
        end
        if (hund != 8'd0 || tens != 8'd0) begin
            conv_buf[conv_len] = 8'h30 + tens;
            conv_len = conv_len + 4'd1;
        end
        conv_buf[conv_len] = 8'h30 + ones;
        conv_len = conv_len + 4'd1;
        if (col != n_q - 3'd1) begin
            conv_buf[conv_len] = SEP_CHAR;
            conv_len = conv_len + 4'd1;
        end
    end

`ifdef MATRIX_DISP_HEADER_EN
    logic       hdr_phase;
    logic [7:0] hdr_buf [0:8];
    logic [3:0] hdr_len;

    always_comb begin
        hdr_buf    = '{default: 8'h00};
        hdr_buf[0] = 8'h4D;
        if (id_q >= 4'd10) begin
            hdr_buf[1] = 8'h31;
            hdr_buf[2] = 8'h30 + {4'd0, id_q - 4'd10};
            hdr_len    = 4'd3;
        end else begin
            hdr_buf[1] = 8'h30 + {4'd0, id_q};
            hdr_len    = 4'd2;
        end
        hdr_buf[hdr_len]        = 8'h3A;
        hdr_buf[hdr_len + 4'd1] = 8'h30 + {5'd0, m_q};
        hdr_buf[hdr_len + 4'd2] = 8'h78;
        hdr_buf[hdr_len + 4'd3] = 8'h30 + {5'd0, n_q};
        hdr_buf[hdr_len + 4'd4] = 8'h0D;
        hdr_buf[hdr_len + 4'd5] = 8'h0A;
        hdr_len = hdr_len + 4'd6;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            id_q         <= 4'd0;
            m_q          <= 3'd0;
            n_q          <= 3'd0;
            row          <= 3'd0;
            col          <= 3'd0;
            meta_cnt     <= 8'd0;
            elem_q       <= 8'd0;
            store_err_q  <= 1'b0;
            char_buf     <= '{default: 8'h00};
            char_len     <= 4'd0;
            char_idx     <= 4'd0;
            start_disp_q <= 1'b0;
            read_en_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef MATRIX_DISP_HEADER_EN
            hdr_phase    <= 1'b0;
`endif
        end else begin
            store_err_q <= bus.store_err;
            case (state)
                IDLE: begin
                    if (bus.disp_req) begin
                        if (bus.disp_m >= 3'd1 && bus.disp_m <= 3'd5 &&
                            bus.disp_n >= 3'd1 && bus.disp_n <= 3'd5) begin
                            id_q         <= bus.disp_id;
                            m_q          <= bus.disp_m;
                            n_q          <= bus.disp_n;
                            row          <= 3'd0;
                            col          <= 3'd0;
                            busy_q       <= 1'b1;
                            start_disp_q <= 1'b1;
                            state        <= REQ;
                        end else begin
                            err_q <= 1'b1;
                            state <= FAIL;
                        end
                    end
                end
                REQ: begin
                    start_disp_q <= 1'b0;
                    meta_cnt     <= 8'd0;
                    state        <= WAIT_META;
                end
                WAIT_META: begin
                    if (bus.meta_valid) begin
`ifdef MATRIX_DISP_HEADER_EN
                        char_buf   <= hdr_buf;
                        char_len   <= hdr_len;
                        char_idx   <= 4'd0;
                        hdr_phase  <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= hdr_buf[0];
                        state      <= EMIT;
`else
                        read_en_q <= 1'b1;
                        state     <= FETCH;
`endif
                    end else if ((bus.store_err && !store_err_q) ||
                                 (meta_cnt + 8'd1 == 8'(META_TIMEOUT))) begin
                        err_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= FAIL;
                    end else begin
                        meta_cnt <= meta_cnt + 8'd1;
                    end
                end
                FETCH: begin
                    read_en_q <= 1'b0;
                    state     <= WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (bus.elem_valid) begin
                        elem_q <= bus.elem_data;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    char_buf   <= conv_buf;
                    char_len   <= conv_len;
                    char_idx   <= 4'd0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= conv_buf[0];
                    state      <= EMIT;
                end
                EMIT: begin
                    // The separator, when needed, is already the last entry of char_buf.
                    if (bus.tx_ready) begin
                        if (char_idx + 4'd1 < char_len) begin
                            char_idx  <= char_idx + 4'd1;
                            tx_data_q <= char_buf[char_idx + 4'd1];
`ifdef MATRIX_DISP_HEADER_EN
                        end else if (hdr_phase) begin
                            hdr_phase  <= 1'b0;
                            tx_valid_q <= 1'b0;
                            read_en_q  <= 1'b1;
                            state      <= FETCH;
`endif
                        end else if (col != n_q - 3'd1) begin
                            col        <= col + 3'd1;
                            tx_valid_q <= 1'b0;
                            read_en_q  <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            tx_data_q <= 8'h0D;
                            state     <= EOL_CR;
                        end
                    end
                end
                EOL_CR: begin
                    if (bus.tx_ready) begin
                        tx_data_q <= 8'h0A;
                        state     <= EOL_LF;
                    end
                end
                EOL_LF: begin
                    if (bus.tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (row != m_q - 3'd1) begin
                            row       <= row + 3'd1;
                            col       <= 3'd0;
                            read_en_q <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= FIN;
                        end
                    end
                end
                FIN: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                FAIL: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start_disp    = start_disp_q;
    assign bus.matrix_id_out = id_q;
    assign bus.read_en       = read_en_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;
endmodule

// File: doc/matrix_disp_formatter.md
Name: matrix_disp_formatter

Overview:
- Display stage directly downstream of matrix storage.
- On a display request it drives the storage read handshake (`start_disp`, `read_en`) and fetches one element at a time.
- Each signed 8-bit element is converted to decimal ASCII and streamed as text bytes to the UART transmitter through a valid/ready handshake.
- One request prints one stored matrix as m rows of n elements.

Parameters:
- META_TIMEOUT, 15: cycles to wait for `meta_valid` after `start_disp` before declaring an error.
- SEP_CHAR, 8'h20: byte emitted between elements of the same row.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- disp_req  input  1  one-cycle request to print a matrix
- disp_id  input  4  matrix slot to print
- disp_m  input  3  row count of that slot (1..5)
- disp_n  input  3  column count of that slot (1..5)
- start_disp  output  1  one-cycle pulse to storage
- matrix_id_out  output  4  slot id presented to storage; held for the whole operation
- read_en  output  1  one-cycle element fetch pulse to storage
- meta_valid  input  1  storage accepted the display request
- elem_data  input  8  element from storage, signed
- elem_valid  input  1  `elem_data` valid for this cycle
- store_err  input  1  storage error flag
- tx_data  output  8  ASCII byte
- tx_valid  output  1  `tx_data` valid
- tx_ready  input  1  transmitter accepts the byte
- busy  output  1  high from request acceptance until done/err
- done  output  1  one-cycle pulse, matrix fully sent
- err  output  1  one-cycle pulse, operation aborted

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset asserted mid-operation aborts immediately with no done/err pulse.
- States: IDLE, REQ, WAIT_META, FETCH, WAIT_DATA, CONV, EMIT, EOL_CR, EOL_LF, FIN, FAIL.
- IDLE:
  - `disp_req` with disp_m and disp_n both in 1..5: latch id/m/n, set `busy`, go to REQ.
  - Out-of-range dims: go to FAIL without pulsing `start_disp`.
  - `disp_req` while `busy` is ignored.
- REQ: assert `start_disp` for one cycle, then go to WAIT_META with the timeout counter cleared.
- WAIT_META:
  - `meta_valid` → FETCH.
  - `store_err` rising while here, or counter reaching META_TIMEOUT → FAIL.
- FETCH: assert `read_en` for one cycle → WAIT_DATA.
- WAIT_DATA: `elem_valid` → latch `elem_data` → CONV. Storage returns data the cycle after `read_en`; no timeout applies here.
- CONV (one cycle):
  - sign = bit7; magnitude = two's-complement absolute value (0..128, 8-bit unsigned).
  - Hundreds, tens, ones digits by constant compare/subtract. No divider.
  - Build the character list: optional '-', then digits with leading zeros suppressed; value 0 prints "0".
  - List length is 1..4 characters; -128 → "-128", 127 → "127".
- EMIT:
  - Present characters in order. `tx_valid` stays high, `tx_data` stays stable until `tx_ready`.
  - A byte transfers on the cycle `tx_valid && tx_ready`.
  - Next byte appears the following cycle; no bubble is required between bytes of one element.
  - After the last digit: if column < n-1, emit SEP_CHAR, advance column, go to FETCH. Otherwise go to EOL_CR.
  - No trailing separator at the end of a row.
- EOL_CR: emit 8'h0D. EOL_LF: emit 8'h0A.
- After LF: if row < m-1, advance row, clear column, go to FETCH. Otherwise go to FIN.
- FIN: pulse `done`, clear `busy` → IDLE.
- FAIL: pulse `err`, clear `busy` → IDLE.
- Counters: row and column are 3-bit. Total fetches per operation = m*n, maximum 25.

Optional Feature:
- Macro: MATRIX_DISP_HEADER_EN.
- When defined:
  - Before the first FETCH, emit the header "M", the id digit(s) in decimal, ':', the m digit, 'x', the n digit, CR, LF.
  - Ids 10..15 print as two digits.
  - Header bytes obey the same tx handshake rules.
- When undefined: output begins directly with the first element.

Test Plan:
- 2x3 slot 4 with elements 1,-2,0,127,-128,10, tx_ready held 1 → "1 -2 0\r\n127 -128 10\r\n"; exactly 6 `read_en` pulses; `done` pulses one cycle after the final LF transfers.
- Same as above, with tx_ready toggling 1-of-3 cycles → identical byte stream; `tx_data` never changes while `tx_valid` is high and `tx_ready` is low.
- disp_m=0 or disp_n=6 → `err` pulse, no `start_disp`, `busy` high for at most 2 cycles.
- `meta_valid` never asserts → `err` pulse 16 cycles after `start_disp`; no `read_en` issued.
- Second `disp_req` mid-print plus reset asserted after the 3rd byte → second request ignored; after reset, all outputs are 0 and a new 1x1 print of 5 yields "5\r\n".
- With MATRIX_DISP_HEADER_EN, 1x1 slot 12, value -7 → "M12:1x1\r\n-7\r\n".
